// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, instruction
// classes, opcodes, immediate-generator modes, ALU ops, PC-source and writeback selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP, CLS_ILLEGAL
  } cls_e;

  localparam logic [2:0] IMM_NONE  = 3'd0;
  localparam logic [2:0] IMM_I     = 3'd1;
  localparam logic [2:0] IMM_SHAMT = 3'd2;
  localparam logic [2:0] IMM_U     = 3'd3;
  localparam logic [2:0] IMM_J     = 3'd4;
  localparam logic [2:0] IMM_B     = 3'd5;
  localparam logic [2:0] IMM_S     = 3'd6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_ALU    = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  // alt selects SUB over ADD (f3=000) and SRA over SRL (f3=101)
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: class, immediate mode, ALU op/operand selects, illegal.
// Zero latency; no handshake, the caller holds inst stable while the result is used.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] inst,
  output cls_e        cls,
  output logic [2:0]  imm_mode,
  output logic [3:0]  alu_op,
  output logic        alu_a_src,
  output logic        alu_b_src,
  output logic        illegal
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_bits;

  assign opc  = inst[6:0];
  assign f3   = inst[14:12];
  assign f7b5 = inst[30];
  assign unused_bits = ^{inst[31], inst[29:15], inst[11:7]};

  always_comb begin
    cls       = CLS_ILLEGAL;
    imm_mode  = IMM_NONE;
    alu_op    = ALU_ADD;
    alu_a_src = 1'b0;
    alu_b_src = 1'b0;
    case (opc)
      OPC_LUI: begin
        cls = CLS_LUI; imm_mode = IMM_U; alu_b_src = 1'b1;
      end
      OPC_AUIPC: begin
        cls = CLS_AUIPC; imm_mode = IMM_U; alu_a_src = 1'b1; alu_b_src = 1'b1;
      end
      OPC_JAL: begin
        cls = CLS_JAL; imm_mode = IMM_J; alu_a_src = 1'b1; alu_b_src = 1'b1;
      end
      OPC_JALR: begin
        cls = CLS_JALR; imm_mode = IMM_I; alu_b_src = 1'b1;
      end
      OPC_BRANCH: begin
        cls = CLS_BRANCH; imm_mode = IMM_B; alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        cls = CLS_LOAD; imm_mode = IMM_I; alu_b_src = 1'b1;
      end
      OPC_STORE: begin
        cls = CLS_STORE; imm_mode = IMM_S; alu_b_src = 1'b1;
      end
      OPC_OPIMM: begin
        cls       = CLS_OPIMM;
        alu_b_src = 1'b1;
        // shifts take a 5-bit shamt; funct7[5] only matters for SRAI
        imm_mode  = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
        alu_op    = alu_from_f3(f3, (f3 == 3'b101) && f7b5);
      end
      OPC_OP: begin
        cls = CLS_OP; imm_mode = IMM_NONE; alu_op = alu_from_f3(f3, f7b5);
      end
      default: ;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM; 3-5 cycles per instruction, +1 per mem_ready stall.
// Fetch/MEM hold until mem_ready; outputs gated low while rstn=0. Optional CTRL_PERF_CNT_EN counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [2:0]  RESET_STATE = 3'd0,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_mode,
  output logic        alu_a_src,
  output logic        alu_b_src,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [2:0]  state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  state_e      state_q, state_d;
  cls_e        cls;
  logic [2:0]  dec_imm;
  logic [3:0]  dec_alu;
  logic        dec_a, dec_b, illegal;
  logic [31:0] wait_q;
  logic        waiting, timeout;

  ctrl_decode u_decode (
    .inst      (inst),
    .cls       (cls),
    .imm_mode  (dec_imm),
    .alu_op    (dec_alu),
    .alu_a_src (dec_a),
    .alu_b_src (dec_b),
    .illegal   (illegal)
  );

  // counts stalled cycles of the current memory access; more than MEM_TIMEOUT traps
  assign waiting = (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wait_q >= MEM_TIMEOUT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= state_e'(RESET_STATE);
      wait_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= waiting ? wait_q + 32'd1 : 32'd0;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_PLUS4;
    imm_mode     = IMM_NONE;
    alu_a_src    = 1'b0;
    alu_b_src    = 1'b0;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    // reset drops every enable and select combinationally, not just at the next edge
    if (rstn) begin
      // keep the operand selects steady from EXEC through WB so the ALU result stays valid
      if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
        imm_mode  = dec_imm;
        alu_a_src = dec_a;
        alu_b_src = dec_b;
        alu_op    = dec_alu;
      end
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          if (timeout)        state_d = ST_TRAP;
          else if (mem_ready) state_d = ST_DECODE;
        end
        ST_DECODE: state_d = illegal ? ST_TRAP : ST_EXEC;
        ST_EXEC: begin
          if (cls == CLS_BRANCH) begin
            pc_we   = 1'b1;
            pc_src  = br_taken ? PC_BRANCH : PC_PLUS4;
            state_d = ST_FETCH;
          end else if (cls == CLS_LOAD || cls == CLS_STORE) begin
            state_d = ST_MEM;
          end else begin
            state_d = ST_WB;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (cls == CLS_STORE);
          if (timeout) begin
            state_d = ST_TRAP;
          end else if (mem_ready) begin
            if (cls == CLS_STORE) begin
              pc_we   = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_we  = (inst[11:7] != 5'd0);
          pc_we   = 1'b1;
          state_d = ST_FETCH;
          case (cls)
            CLS_JAL:  begin pc_src = PC_BRANCH; wb_sel = WB_PC4; end
            CLS_JALR: begin pc_src = PC_ALU;    wb_sel = WB_PC4; end
            CLS_LOAD: wb_sel = WB_MEM;
            CLS_LUI:  wb_sel = WB_IMM;
            default:  ;
          endcase
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_TRAP;
      endcase
    end
  end

  assign trap  = (state_q == ST_TRAP);
  assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cycle_cnt   <= 64'd0;
      instret_cnt <= 64'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (pc_we) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expectations queued with the stimulus,
// compared at the falling edge.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] inst = 32'd0;
  logic        mem_ready = 1'b0;
  logic        br_taken = 1'b0;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  imm_mode, state;
  logic        alu_a_src, alu_b_src, reg_we, trap;
  logic [3:0]  alu_op;
`ifdef CTRL_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_STATE(3'd0), .MEM_TIMEOUT(0)) dut (
    .clk(clk), .rstn(rstn), .inst(inst), .mem_ready(mem_ready), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .imm_mode(imm_mode), .alu_a_src(alu_a_src),
    .alu_b_src(alu_b_src), .alu_op(alu_op), .reg_we(reg_we), .wb_sel(wb_sel),
    .trap(trap), .state(state)
`ifdef CTRL_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  localparam logic [31:0] I_ADDI = 32'h00500093;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BEQ  = 32'h00000463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BAD  = 32'h00000000;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, asel, irwe, pcwe;
    logic [1:0] pcsrc;
    logic [2:0] imm;
    logic [3:0] aluop;
    logic       bsrc, regwe;
    logic [1:0] wbsel;
    logic       trap;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int st, input int req, input int we, input int asel,
                              input int irwe, input int pcwe, input int pcsrc, input int imm,
                              input int aluop, input int bsrc, input int regwe, input int wbsel,
                              input int tr);
    exp_t e;
    e.st = 3'(st);   e.req = 1'(req);     e.we = 1'(we);       e.asel = 1'(asel);
    e.irwe = 1'(irwe); e.pcwe = 1'(pcwe); e.pcsrc = 2'(pcsrc); e.imm = 3'(imm);
    e.aluop = 4'(aluop); e.bsrc = 1'(bsrc); e.regwe = 1'(regwe); e.wbsel = 2'(wbsel);
    e.trap = 1'(tr);
    return e;
  endfunction

  function automatic exp_t f_cyc(input int rdy);
    return mk(0, 1, 0, 0, rdy, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic exp_t d_cyc();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cyc++;
      check($sformatf("c%0d.state", n_cyc), 32'(state), 32'(e.st));
      check($sformatf("c%0d.mem_req", n_cyc), 32'(mem_req), 32'(e.req));
      check($sformatf("c%0d.mem_we", n_cyc), 32'(mem_we), 32'(e.we));
      check($sformatf("c%0d.addr_sel", n_cyc), 32'(mem_addr_sel), 32'(e.asel));
      check($sformatf("c%0d.ir_we", n_cyc), 32'(ir_we), 32'(e.irwe));
      check($sformatf("c%0d.pc_we", n_cyc), 32'(pc_we), 32'(e.pcwe));
      check($sformatf("c%0d.reg_we", n_cyc), 32'(reg_we), 32'(e.regwe));
      check($sformatf("c%0d.trap", n_cyc), 32'(trap), 32'(e.trap));
      if (e.st == 3'd2) begin
        check($sformatf("c%0d.imm_mode", n_cyc), 32'(imm_mode), 32'(e.imm));
        check($sformatf("c%0d.alu_op", n_cyc), 32'(alu_op), 32'(e.aluop));
        check($sformatf("c%0d.alu_b_src", n_cyc), 32'(alu_b_src), 32'(e.bsrc));
      end
      if (e.pcwe) check($sformatf("c%0d.pc_src", n_cyc), 32'(pc_src), 32'(e.pcsrc));
      if (e.st == 3'd4) check($sformatf("c%0d.wb_sel", n_cyc), 32'(wb_sel), 32'(e.wbsel));
    end
  end

  task automatic step(input logic [31:0] iv, input logic rdy, input logic br, input exp_t e);
    @(posedge clk);
    #1;
    inst = iv; mem_ready = rdy; br_taken = br;
    sb.push_back(e);
  endtask

  task automatic start(input logic [31:0] iv, input logic rdy);
    @(posedge clk);
    #1;
    rstn = 1'b1; inst = iv; mem_ready = rdy; br_taken = 1'b0;
    sb.push_back(f_cyc(rdy));
  endtask

  initial begin
    #12;
    check("rst.state", 32'(state), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.trap", 32'(trap), 32'd0);
    check("rst.ir_we", 32'(ir_we), 32'd0);
    check("rst.pc_we", 32'(pc_we), 32'd0);

    // ADDI x1,x0,5: FETCH, DECODE, EXEC, WB
    start(I_ADDI, 1'b1);
    step(I_ADDI, 1'b1, 1'b0, d_cyc());
    step(I_ADDI, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    step(I_ADDI, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));

    // LW x2,0(x1) with two MEM stalls
    step(I_LW, 1'b1, 1'b0, f_cyc(1));
    step(I_LW, 1'b1, 1'b0, d_cyc());
    step(I_LW, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    step(I_LW, 1'b0, 1'b0, mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(I_LW, 1'b0, 1'b0, mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(I_LW, 1'b1, 1'b0, mk(3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(I_LW, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));

    // SW x2,4(x1)
    step(I_SW, 1'b1, 1'b0, f_cyc(1));
    step(I_SW, 1'b1, 1'b0, d_cyc());
    step(I_SW, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 6, 0, 1, 0, 0, 0));
    step(I_SW, 1'b1, 1'b0, mk(3, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    // BEQ taken then not taken
    for (int t = 1; t >= 0; t--) begin
      step(I_BEQ, 1'b1, 1'b0, f_cyc(1));
      step(I_BEQ, 1'b1, 1'b0, d_cyc());
      step(I_BEQ, 1'b1, 1'(t), mk(2, 0, 0, 0, 0, 1, t, 5, 1, 0, 0, 0, 0));
    end

    // JAL x1,8 with one fetch stall
    step(I_JAL, 1'b0, 1'b0, f_cyc(0));
    step(I_JAL, 1'b1, 1'b0, f_cyc(1));
    step(I_JAL, 1'b1, 1'b0, d_cyc());
    step(I_JAL, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0, 0));
    step(I_JAL, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 2, 0));

    // illegal opcode: TRAP is absorbing, mem_ready toggling is ignored
    step(I_BAD, 1'b1, 1'b0, f_cyc(1));
    step(I_BAD, 1'b1, 1'b0, d_cyc());
    for (int i = 0; i < 20; i++)
      step(I_BAD, 1'(i & 1), 1'(i & 1), mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("trap_rst.state", 32'(state), 32'd0);
    check("trap_rst.trap", 32'(trap), 32'd0);

    // reset asserted mid-FETCH kills mem_req at once
    start(I_ADDI, 1'b0);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("fetch_rst.mem_req", 32'(mem_req), 32'd0);
    check("fetch_rst.state", 32'(state), 32'd0);
    check("fetch_rst.ir_we", 32'(ir_we), 32'd0);

    // fetch restarts cleanly after release
    start(I_ADDI, 1'b1);
    step(I_ADDI, 1'b1, 1'b0, d_cyc());
    step(I_ADDI, 1'b1, 1'b0, mk(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    step(I_ADDI, 1'b1, 1'b0, mk(4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0));
    @(posedge clk);
    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Decodes the latched instruction into datapath selects, including the 3-bit immediate-generator mode, ALU op, PC source and write enables.
- Arbitrates the single shared memory port between instruction fetch and load/store through a req/ready handshake.

Parameters:
- RESET_STATE, 3'd0 (FETCH): state entered on reset; fixed, exposed for bench visibility only.
- MEM_TIMEOUT, 0: if nonzero, a wait of more than MEM_TIMEOUT cycles on mem_ready enters TRAP; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- inst  in  32  IR contents; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current request this cycle.
- br_taken  in  1  ALU compare result; valid in EXEC.
- mem_req  out  1  memory access request.
- mem_we  out  1  store when 1; qualifies mem_req.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (load/store).
- ir_we  out  1  latch fetched word into IR.
- pc_we  out  1  update PC.
- pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result & ~1.
- imm_mode  out  3  immediate-generator mode.
- alu_a_src  out  1  0 = rs1, 1 = PC.
- alu_b_src  out  1  0 = rs2, 1 = imm.
- alu_op  out  4  ALU function code.
- reg_we  out  1  register file write.
- wb_sel  out  2  0 = ALU, 1 = mem data, 2 = PC+4, 3 = imm.
- trap  out  1  sticky illegal-instruction / timeout flag.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (asynchronous, rstn=0):
  - state=FETCH, trap=0.
  - All enables and mem_req drop to 0 immediately; selects go to 0.
  - A memory transaction in flight is abandoned.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- All outputs are Moore (state plus registered IR decode) except ir_we and the MEM-state completion, which are qualified by mem_ready.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - Hold until mem_ready; in the mem_ready cycle assert ir_we, then go to DECODE.
- DECODE: one cycle, no enables. Opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP} -> TRAP.
- EXEC: imm_mode, alu_* driven. Next state by class:
  - BRANCH: pc_we=1; pc_src=1 if br_taken, else 0; go to FETCH.
  - LOAD/STORE: go to MEM.
  - All others: go to WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - Hold until mem_ready.
  - STORE: pc_we=1, pc_src=0, go to FETCH.
  - LOAD: go to WB.
- WB:
  - reg_we=1 unless rd=0.
  - pc_we=1; pc_src = 1 for JAL, 2 for JALR, 0 otherwise.
  - Go to FETCH.
- TRAP: trap=1, all enables 0, absorbing until reset.
- Cycle counts with mem_ready tied high: OP/OP-IMM/LUI/AUIPC/JAL/JALR = 4; LOAD = 5; STORE = 4; BRANCH = 3.
- Every mem_ready stall adds one cycle.
- pc_we is asserted exactly once per retired instruction.
- mem_ready seen outside FETCH/MEM is ignored.
- imm_mode encoding: 0 none (R-type), 1 I-type (also loads and JALR), 2 shamt (SLLI/SRLI/SRAI), 3 U, 4 J, 5 B, 6 S, 7 reserved (never driven).
- alu_op: derived from funct3 and funct7[5] for OP; from funct3 for OP-IMM (funct7[5] only for SRAI); ADD for LOAD/STORE/AUIPC/JALR; SUB for BRANCH compare.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined: adds outputs cycle_cnt[63:0] (increments every cycle outside reset) and instret_cnt[63:0] (increments on each pc_we); both reset to 0 and wrap at 2^64.
- When undefined: the ports and the logic are absent.

Decomposition:
- Shared package ctrl_pkg holds:
  - state enum;
  - imm_mode constants (IMM_NONE..IMM_S);
  - opcode constants;
  - alu_op codes;
  - pc_src and wb_sel encodings.
- One sub-module, ctrl_decode: purely combinational, inst -> class, imm_mode, alu_op, illegal. The FSM lives in multicycle_ctrl.

Test Plan:
- ADDI x1,x0,5 (0x00500093), mem_ready=1 -> states 0,1,2,4; imm_mode=1 in EXEC; reg_we=1 and pc_we=1 (pc_src=0) in WB; 4 cycles.
- LW x2,0(x1) (0x0000A103), mem_ready low 2 cycles in MEM -> MEM held 3 cycles; reg_we in WB with wb_sel=1; 7 cycles total.
- SW x2,4(x1) (0x0020A223) -> imm_mode=6; mem_we=1 and pc_we=1 in the MEM ready cycle; reg_we never asserted.
- BEQ x0,x0,8 (0x00000463), br_taken=1 -> imm_mode=5, pc_we with pc_src=1 in EXEC; 3 cycles. Repeat with br_taken=0 -> pc_src=0.
- inst=0x00000000 -> TRAP after DECODE; trap=1 held and no enables for 20 cycles. Then rstn low mid-state -> FETCH, trap=0 asynchronously.
- rstn asserted during FETCH with mem_req=1 -> mem_req=0 in the same cycle; fetch restarts after release.
